axil_gpio_slave: RTL and testbench

AXIL_GPIO_SLAVE -- requirements
Module: axil_gpio_slave

---
 rtl/axil_pkg.sv | 32 +++
 rtl/axil_gpio_slave_if.sv | 38 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/axil_gpio_slave.sv | 171 +++++++++++++++++
 tb/tb_axil_gpio_slave.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite GPIO definitions: response codes, register offsets, byte-merge helper.
package axil_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = 7;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    localparam logic [IDX_W-1:0] GPIO_DATA_OFS = 7'd0;
    localparam logic [IDX_W-1:0] GPIO_TRI_OFS  = 7'd1;

    // Replace the bytes of old_val selected by strb with the matching bytes of new_val.
    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_gpio_slave_if.sv
// AXI4-Lite bus bundle between a master and the GPIO slave.
interface axil_gpio_slave_if #(
    parameter int unsigned ADDR_W = 9
) ();

    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/axil_gpio_slave.sv
// AXI4-Lite slave exposing a 32-bit GPIO DATA register and a TRI (direction) register.
module axil_gpio_slave
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W    = 9,
    parameter logic [31:0] TRI_RESET = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    axil_gpio_slave_if.slave    bus,
    input  logic [DATA_W-1:0]   gpio_io_i,
    output logic [DATA_W-1:0]   gpio_io_o,
    output logic [DATA_W-1:0]   gpio_io_t
);

    // Register state
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] tri_q;
    logic [DATA_W-1:0] pins_sync;

    // Write-side holders and response
    logic              aw_full_q;
    logic              w_full_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              aw_ready_q;
    logic              w_ready_q;
    logic              bvalid_q;
    resp_t             bresp_q;

    // Read-side state
    logic              ar_ready_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    resp_t             rresp_q;

    // Combinational helpers
    logic [ADDR_W-1:0] awaddr_c;
    logic [ADDR_W-1:0] araddr_c;
    logic              aw_hs_c;
    logic              w_hs_c;
    logic              b_hs_c;
    logic              ar_hs_c;
    logic              r_hs_c;
    logic              commit_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic [DATA_W-1:0] wr_data_c;
    logic [STRB_W-1:0] wr_strb_c;
    logic              aw_full_d;
    logic              w_full_d;
    logic              bvalid_d;
    logic              rvalid_d;
    logic [IDX_W-1:0]  rd_idx_c;
    logic [DATA_W-1:0] rd_val_c;
    resp_t             rd_resp_c;
    logic              unused_addr_bits;

    assign awaddr_c = bus.s_axi_awaddr;
    assign araddr_c = bus.s_axi_araddr;
    assign unused_addr_bits = ^{awaddr_c[1:0], araddr_c[1:0]};

    // Pin inputs are asynchronous; only the synchronized copy is used.
    sync_2ff #(.WIDTH(DATA_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpio_io_i),
        .q     (pins_sync)
    );

    // Handshakes, write commit condition and next-state of the channel flags.
    always_comb begin
        aw_hs_c   = bus.s_axi_awvalid & aw_ready_q;
        w_hs_c    = bus.s_axi_wvalid & w_ready_q;
        b_hs_c    = bvalid_q & bus.s_axi_bready;
        ar_hs_c   = bus.s_axi_arvalid & ar_ready_q;
        r_hs_c    = rvalid_q & bus.s_axi_rready;
        wr_idx_c  = aw_full_q ? aw_idx_q : awaddr_c[8:2];
        wr_data_c = w_full_q ? w_data_q : bus.s_axi_wdata;
        wr_strb_c = w_full_q ? w_strb_q : bus.s_axi_wstrb;
        commit_c  = (aw_full_q | aw_hs_c) & (w_full_q | w_hs_c) & ~bvalid_q;
        aw_full_d = b_hs_c ? 1'b0 : (aw_full_q | aw_hs_c);
        w_full_d  = b_hs_c ? 1'b0 : (w_full_q | w_hs_c);
        bvalid_d  = commit_c | (bvalid_q & ~b_hs_c);
        rvalid_d  = ar_hs_c | (rvalid_q & ~r_hs_c);
    end

    // Read data mux: input bits come from the pins, output bits from DATA.
    always_comb begin
        rd_idx_c  = araddr_c[8:2];
        rd_val_c  = '0;
        rd_resp_c = OKAY;
        if (rd_idx_c == GPIO_DATA_OFS) begin
            rd_val_c = (pins_sync & tri_q) | (data_q & ~tri_q);
        end else if (rd_idx_c == GPIO_TRI_OFS) begin
            rd_val_c = tri_q;
        end else begin
            rd_resp_c = SLVERR;
        end
    end

    // Write channel: AW/W holders, register update on commit, B response.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            data_q     <= '0;
            tri_q      <= TRI_RESET;
        end else begin
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            aw_ready_q <= ~aw_full_d & ~bvalid_d;
            w_ready_q  <= ~w_full_d & ~bvalid_d;
            bvalid_q   <= bvalid_d;
            if (aw_hs_c) begin
                aw_idx_q <= awaddr_c[8:2];
            end
            if (w_hs_c) begin
                w_data_q <= bus.s_axi_wdata;
                w_strb_q <= bus.s_axi_wstrb;
            end
            if (commit_c) begin
                if (wr_idx_c == GPIO_DATA_OFS) begin
                    data_q  <= apply_wstrb(data_q, wr_data_c, wr_strb_c);
                    bresp_q <= OKAY;
                end else if (wr_idx_c == GPIO_TRI_OFS) begin
                    tri_q   <= apply_wstrb(tri_q, wr_data_c, wr_strb_c);
                    bresp_q <= OKAY;
                end else begin
                    bresp_q <= SLVERR;
                end
            end
        end
    end

    // Read channel: sample register contents at the AR handshake, hold until R handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            ar_ready_q <= ~rvalid_d;
            rvalid_q   <= rvalid_d;
            if (ar_hs_c) begin
                rdata_q <= rd_val_c;
                rresp_q <= rd_resp_c;
            end
        end
    end

    assign bus.s_axi_awready = aw_ready_q;
    assign bus.s_axi_wready  = w_ready_q;
    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_bresp   = bresp_q;
    assign bus.s_axi_arready = ar_ready_q;
    assign bus.s_axi_rvalid  = rvalid_q;
    assign bus.s_axi_rdata   = rdata_q;
    assign bus.s_axi_rresp   = rresp_q;
    assign gpio_io_o         = data_q;
    assign gpio_io_t         = tri_q;

endmodule

// File: tb/tb_axil_gpio_slave.sv
// Self-checking bench for axil_gpio_slave: directed scenarios followed by randomized traffic.
module tb_axil_gpio_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pins;
    logic [31:0] gpio_o;
    logic [31:0] gpio_t;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state
    logic [31:0] m_data;
    logic [31:0] m_tri;

    axil_gpio_slave_if #(.ADDR_W(9)) bus ();

    axil_gpio_slave #(.ADDR_W(9), .TRI_RESET(32'hFFFF_FFFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .gpio_io_i (pins),
        .gpio_io_o (gpio_o),
        .gpio_io_t (gpio_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of a write: returns the expected response and updates the registers.
    function automatic logic [1:0] m_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] tgt;
        logic [6:0]  idx;
        idx = a[8:2];
        if (idx > 7'd1) return 2'b10;
        tgt = (idx == 7'd0) ? m_data : m_tri;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) tgt[8*b +: 8] = d[8*b +: 8];
        end
        if (idx == 7'd0) m_data = tgt;
        else m_tri = tgt;
        return 2'b00;
    endfunction

    // Model of a read with pins assumed stable long enough to be synchronized.
    function automatic logic [31:0] m_read(input logic [8:0] a);
        logic [6:0] idx;
        idx = a[8:2];
        if (idx == 7'd0) return (pins & m_tri) | (m_data & ~m_tri);
        if (idx == 7'd1) return m_tri;
        return 32'h0;
    endfunction

    function automatic logic [8:0] rand_addr();
        logic [6:0] idx;
        case ($urandom_range(0, 3))
            0:       idx = 7'd0;
            1:       idx = 7'd1;
            2:       idx = 7'($urandom_range(2, 126));
            default: idx = 7'd127;
        endcase
        return {idx, 2'($urandom_range(0, 3))};
    endfunction

    task automatic do_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int unsigned aw_dly, input int unsigned w_dly);
        logic        aw_done, w_done, aw_go, w_go;
        int unsigned cyc;
        logic [1:0]  exp_resp;
        bus.s_axi_awaddr = a;
        bus.s_axi_wdata  = d;
        bus.s_axi_wstrb  = s;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            bus.s_axi_wvalid  = !w_done && (cyc >= w_dly);
            aw_go = bus.s_axi_awvalid && bus.s_axi_awready;
            w_go  = bus.s_axi_wvalid && bus.s_axi_wready;
            tick();
            aw_done = aw_done | aw_go;
            w_done  = w_done | w_go;
            cyc++;
            if (w_done && !aw_done) chk("wready_held", 32'(bus.s_axi_wready), 32'd0);
            if (aw_done && !w_done) chk("awready_held", 32'(bus.s_axi_awready), 32'd0);
            if (!(aw_done && w_done)) chk("bvalid_early", 32'(bus.s_axi_bvalid), 32'd0);
        end
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            checks++;
            errors++;
            $error("FAIL write_timeout: addr=%h aw_done=%0d w_done=%0d", a, aw_done, w_done);
            return;
        end
        chk("b_latency", 32'(bus.s_axi_bvalid), 32'd1);
        exp_resp = m_write(a, d, s);
        chk("bresp", 32'(bus.s_axi_bresp), 32'(exp_resp));
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0;
        chk("bvalid_clear", 32'(bus.s_axi_bvalid), 32'd0);
        chk("gpio_io_o", gpio_o, m_data);
        chk("gpio_io_t", gpio_t, m_tri);
    endtask

    task automatic do_read(input logic [8:0] a);
        logic        ar_go;
        int unsigned cyc;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bus.s_axi_araddr  = a;
        bus.s_axi_arvalid = 1'b1;
        exp_data = m_read(a);
        exp_resp = (a[8:2] > 7'd1) ? 2'b10 : 2'b00;
        ar_go = 1'b0;
        cyc   = 0;
        while (!ar_go && cyc < 40) begin
            ar_go = bus.s_axi_arready;
            tick();
            cyc++;
        end
        bus.s_axi_arvalid = 1'b0;
        if (!ar_go) begin
            checks++;
            errors++;
            $error("FAIL read_timeout: addr=%h", a);
            return;
        end
        chk("r_latency", 32'(bus.s_axi_rvalid), 32'd1);
        chk("arready_busy", 32'(bus.s_axi_arready), 32'd0);
        chk("rdata", bus.s_axi_rdata, exp_data);
        chk("rresp", 32'(bus.s_axi_rresp), 32'(exp_resp));
        bus.s_axi_rready = 1'b1;
        tick();
        bus.s_axi_rready = 1'b0;
        chk("rvalid_clear", 32'(bus.s_axi_rvalid), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_r;
        logic [1:0]  exp_b;
        int unsigned r;

        reset = 1'b1;
        pins  = 32'h0;
        bus.s_axi_awaddr  = '0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata   = '0;
        bus.s_axi_wstrb   = '0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b0;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = 1'b0;
        m_data = 32'h0;
        m_tri  = 32'hFFFF_FFFF;

        // Reset state
        repeat (3) tick();
        chk("rst_awready", 32'(bus.s_axi_awready), 32'd0);
        chk("rst_wready", 32'(bus.s_axi_wready), 32'd0);
        chk("rst_arready", 32'(bus.s_axi_arready), 32'd0);
        chk("rst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
        chk("rst_bresp", 32'(bus.s_axi_bresp), 32'd0);
        chk("rst_rresp", 32'(bus.s_axi_rresp), 32'd0);
        chk("rst_rdata", bus.s_axi_rdata, 32'd0);
        chk("rst_gpio_o", gpio_o, 32'h0);
        chk("rst_gpio_t", gpio_t, 32'hFFFF_FFFF);
        reset = 1'b0;
        tick();
        chk("post_rst_awready", 32'(bus.s_axi_awready), 32'd1);
        chk("post_rst_wready", 32'(bus.s_axi_wready), 32'd1);
        chk("post_rst_arready", 32'(bus.s_axi_arready), 32'd1);

        // Simultaneous AW/W full-word write
        do_write(9'h000, 32'hDEAD_BEEF, 4'hF, 0, 0);
        chk("dir_full_write", gpio_o, 32'hDEAD_BEEF);

        // W leads AW by 3 cycles, lower halfword only
        do_write(9'h000, 32'h0000_1234, 4'h3, 3, 0);
        chk("dir_partial_write", gpio_o, 32'hDEAD_1234);

        // Mixed direction read-back
        do_write(9'h004, 32'h0000_FFFF, 4'hF, 0, 0);
        pins = 32'hA5A5_5A5A;
        repeat (3) tick();
        do_read(9'h000);
        chk("dir_tri", gpio_t, 32'h0000_FFFF);
        chk("dir_mixed_model", m_read(9'h000), 32'hDEAD_5A5A);

        // Unmapped write and read
        do_write(9'h010, 32'hFFFF_FFFF, 4'hF, 0, 0);
        do_read(9'h010);
        chk("unmapped_data", gpio_o, 32'hDEAD_1234);
        chk("unmapped_tri", gpio_t, 32'h0000_FFFF);

        // Concurrent read and write with responses back-pressured
        exp_r = m_read(9'h000);
        bus.s_axi_araddr  = 9'h000;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_awaddr  = 9'h004;
        bus.s_axi_wdata   = 32'h0000_FFFF;
        bus.s_axi_wstrb   = 4'hF;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        tick();
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        exp_b = m_write(9'h004, 32'h0000_FFFF, 4'hF);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid", 32'(bus.s_axi_rvalid), 32'd1);
            chk("stall_rdata", bus.s_axi_rdata, exp_r);
            chk("stall_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
            chk("stall_bresp", 32'(bus.s_axi_bresp), 32'(exp_b));
            chk("stall_arready", 32'(bus.s_axi_arready), 32'd0);
            chk("stall_awready", 32'(bus.s_axi_awready), 32'd0);
            chk("stall_wready", 32'(bus.s_axi_wready), 32'd0);
            tick();
        end
        bus.s_axi_rready = 1'b1;
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_rready = 1'b0;
        bus.s_axi_bready = 1'b0;
        chk("release_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
        chk("release_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        chk("release_arready", 32'(bus.s_axi_arready), 32'd1);
        chk("release_awready", 32'(bus.s_axi_awready), 32'd1);
        chk("release_wready", 32'(bus.s_axi_wready), 32'd1);

        // Reset with only AW accepted drops the transaction
        bus.s_axi_awaddr  = 9'h000;
        bus.s_axi_awvalid = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0;
        chk("aw_only_awready", 32'(bus.s_axi_awready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_data = 32'h0;
        m_tri  = 32'hFFFF_FFFF;
        chk("midrst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        chk("midrst_gpio_t", gpio_t, 32'hFFFF_FFFF);
        chk("midrst_gpio_o", gpio_o, 32'h0);
        tick();
        chk("midrst_bvalid_after", 32'(bus.s_axi_bvalid), 32'd0);
        do_write(9'h000, 32'h0000_0055, 4'hF, 4, 0);
        chk("post_midrst_write", gpio_o, 32'h0000_0055);

        // Randomized traffic against the model
        repeat (3) tick();
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                pins = $urandom;
                repeat (3) tick();
            end else if (r < 6) begin
                do_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
            end else begin
                do_read(rand_addr());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
